// File: rtl/data_memory_pipelined.sv
// Byte-addressed big-endian data memory with registered reads, access checking and an init sequencer.
// Define DMEM_WRITE_FORWARD_EN for write-first same-cycle reads; the default is read-first.
module data_memory_pipelined #(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter logic [31:0] INIT_WORD   = 32'h0000_0001,
    parameter int unsigned INIT_WORDS  = DEPTH_BYTES / 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Startin,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Busy,
    output logic        Error
);
    localparam int unsigned AW = (DEPTH_BYTES > 2) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned CW = $clog2(DEPTH_BYTES / 4 + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] INIT = 1'b1;

    logic [7:0]    mem [DEPTH_BYTES];

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;
    logic          error_q, error_d;

    logic          accept, legal, do_write, init_we;
    logic [2:0]    nbytes;
    logic [AW-1:0] base, init_base;
    logic [31:0]   wd_lj;
    logic [7:0]    rd_byte [4];
    logic [31:0]   load_val;
    logic          ext;

    assign accept    = (state_q == IDLE);
    assign init_we   = (state_q == INIT);
    assign base      = Address[AW-1:0];
    assign init_base = AW'({cnt_q, 2'b00});

    // Store data left-justified so that byte lane j always maps to bits [31-8j -: 8].
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        nbytes = 3'd4;
        wd_lj  = WriteData;
        case (Size)
            2'b00: begin nbytes = 3'd1; wd_lj = {WriteData[7:0], 24'h0};  end
            2'b01: begin nbytes = 3'd2; wd_lj = {WriteData[15:0], 16'h0}; end
            default: ;
        endcase
        legal = (Size != 2'b11)
             && !(Size == 2'b01 && Address[0])
             && !(Size == 2'b10 && Address[1:0] != 2'b00)
             && ({1'b0, Address} + 33'(nbytes) <= 33'(DEPTH_BYTES));
    end

    assign do_write = accept && MemWrite && legal;

    // Read and write share one address and size, so a same-cycle pair overlaps on every lane.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_byte[k] = 8'h00;
            if (legal && k < int'(nbytes)) begin
`ifdef DMEM_WRITE_FORWARD_EN
                rd_byte[k] = do_write ? wd_lj[31 - 8*k -: 8] : mem[base + AW'(k)];
`else
                rd_byte[k] = mem[base + AW'(k)];
`endif
            end
        end
        ext      = 1'b0;
        load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        case (Size)
            2'b00: begin
                ext      = !Unsigned && rd_byte[0][7];
                load_val = {{24{ext}}, rd_byte[0]};
            end
            2'b01: begin
                ext      = !Unsigned && rd_byte[0][7];
                load_val = {{16{ext}}, rd_byte[0], rd_byte[1]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        read_valid_d = accept && MemRead;
        error_d      = accept && (MemRead || MemWrite) && !legal;
        read_data_d  = read_data_q;
        if (read_valid_d) read_data_d = legal ? load_val : 32'h0;
        case (state_q)
            IDLE: if (Startin) begin
                state_d = INIT;
                cnt_d   = '0;
            end
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(INIT_WORDS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            error_q      <= error_d;
        end
    end

    // NOTE: the array is deliberately not reset; reset only blocks writes at that edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (init_we) begin
                for (int j = 0; j < 4; j++) mem[init_base + AW'(j)] <= INIT_WORD[31 - 8*j -: 8];
            end else if (do_write) begin
                for (int j = 0; j < 4; j++) begin
                    if (j < int'(nbytes)) mem[base + AW'(j)] <= wd_lj[31 - 8*j -: 8];
                end
            end
        end
    end

    assign ReadData  = read_data_q;
    assign ReadValid = read_valid_q;
    assign Busy      = (state_q == INIT);
    assign Error     = error_q;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench for data_memory_pipelined: a byte-array reference model predicts every cycle's outputs.
module tb_data_memory_pipelined;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n, Startin, MemRead, MemWrite, Unsigned;
    logic [31:0] Address, WriteData, ReadData;
    logic [1:0]  Size;
    logic        ReadValid, Busy, Error;

    always #5 clk = ~clk;

    data_memory_pipelined dut (
        .clk(clk), .rst_n(rst_n), .Startin(Startin), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
        .ReadData(ReadData), .ReadValid(ReadValid), .Busy(Busy), .Error(Error)
    );

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl [DEPTH];
    logic [31:0] exp_hold;
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Startin   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        Size      = 2'b00;
        Unsigned  = 1'b0;
    endtask

    task automatic push_idle();
        sb.push_back('{valid: 1'b0, err: 1'b0, data: exp_hold});
    endtask

    // One clock: sample #1 after the edge, pop the prediction made when the inputs were driven.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(ReadValid), 32'(e.valid));
            check({tag, "_err"},   32'(Error),     32'(e.err));
            check({tag, "_data"},  ReadData,       e.data);
        end
        last_rd = ReadData;
        idle_inputs();
    endtask

    task automatic issue(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit uns);
        exp_t        e;
        int          n;
        bit          ok;
        logic [7:0]  b [4];
        logic [31:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ok = (sz != 2'd3) && !(sz == 2'd1 && a[0]) && !(sz == 2'd2 && a[1:0] != 2'd0)
          && ({1'b0, a} + 33'(n) <= 33'(DEPTH));
        for (int k = 0; k < 4; k++) b[k] = 8'h00;
        if (rd && ok) for (int k = 0; k < n; k++) b[k] = mdl[6'(a) + 6'(k)];
        if (wr && ok) for (int j = 0; j < n; j++) mdl[6'(a) + 6'(j)] = wd[8*(n-1-j) +: 8];
`ifdef DMEM_WRITE_FORWARD_EN
        if (rd && ok) for (int k = 0; k < n; k++) b[k] = mdl[6'(a) + 6'(k)];
`endif
        v = 32'h0;
        for (int k = 0; k < n; k++) v = {v[23:0], b[k]};
        if (!uns && n < 4 && b[0][7]) v = v | (32'hFFFF_FFFF << (8*n));
        e.valid  = rd;
        e.err    = (rd || wr) && !ok;
        e.data   = rd ? (ok ? v : 32'h0) : exp_hold;
        exp_hold = e.data;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = a;
        WriteData = wd;
        Size      = sz;
        Unsigned  = uns;
        sb.push_back(e);
        tick(tag);
    endtask

    initial begin
        int busy_cycles;
        idle_inputs();
        rst_n    = 1'b0;
        exp_hold = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",  ReadData,          32'h0);
        check("rst_valid", 32'(ReadValid),    32'd0);
        check("rst_err",   32'(Error),        32'd0);
        check("rst_busy",  32'(Busy),         32'd0);
        rst_n = 1'b1;

        // Full init: Busy must stay high for exactly DEPTH/4 cycles.
        Startin = 1'b1;
        push_idle();
        tick("start");
        busy_cycles = 0;
        for (int i = 0; i < 100 && Busy; i++) begin
            busy_cycles++;
            push_idle();
            tick("init");
        end
        check("busy_len", 32'(busy_cycles), 32'd16);
        for (int w = 0; w < DEPTH / 4; w++) begin
            mdl[4*w] = 8'h00; mdl[4*w+1] = 8'h00; mdl[4*w+2] = 8'h00; mdl[4*w+3] = 8'h01;
        end

        issue("rd_3c", 1, 0, 32'h3C, 32'h0, 2'b10, 0);
        check("rd_3c_const", last_rd, 32'h0000_0001);
        push_idle();
        tick("gap");

        issue("wr_8",    0, 1, 32'h08, 32'hDEAD_BEEF, 2'b10, 0);
        issue("rdb_8",   1, 0, 32'h08, 32'h0, 2'b00, 0);
        check("rdb_8_const", last_rd, 32'hFFFF_FFDE);
        issue("rdbu_b",  1, 0, 32'h0B, 32'h0, 2'b00, 1);
        check("rdbu_b_const", last_rd, 32'h0000_00EF);
        issue("rdh_a",   1, 0, 32'h0A, 32'h0, 2'b01, 0);
        check("rdh_a_const", last_rd, 32'hFFFF_BEEF);

        issue("wrh_11",  0, 1, 32'h11, 32'h0000_1234, 2'b01, 0);
        issue("rd_10",   1, 0, 32'h10, 32'h0, 2'b10, 0);
        check("rd_10_const", last_rd, 32'h0000_0001);
        issue("rd_3e",   1, 0, 32'h3E, 32'h0, 2'b10, 0);
        issue("rdb_40",  1, 0, 32'h40, 32'h0, 2'b00, 0);
        issue("rd_wrap", 1, 0, 32'hFFFF_FFFC, 32'h0, 2'b10, 0);
        issue("rd_sz3",  1, 0, 32'h04, 32'h0, 2'b11, 0);

        issue("rw_20",   1, 1, 32'h20, 32'hCAFE_F00D, 2'b10, 0);
`ifdef DMEM_WRITE_FORWARD_EN
        check("rw_20_const", last_rd, 32'hCAFE_F00D);
`else
        check("rw_20_const", last_rd, 32'h0000_0001);
`endif
        issue("rd_20",   1, 0, 32'h20, 32'h0, 2'b10, 0);

        // Mixed traffic, including back-to-back reads and illegal requests.
        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            issue("rand", rd, wr, 32'($urandom_range(0, 67)), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                push_idle();
                tick("rand_gap");
            end
        end

        // Abort init after five words; a request during Busy must be dropped.
        for (int w = 0; w < 6; w++) issue("pre_abort", 0, 1, 32'(4*w), 32'hA5A5_0000 | 32'(w), 2'b10, 0);
        Startin = 1'b1;
        push_idle();
        tick("start2");
        for (int i = 0; i < 5; i++) begin
            check("abort_busy", 32'(Busy), 32'd1);
            if (i == 2) begin
                MemRead  = 1'b1;
                MemWrite = 1'b1;
                Address  = 32'h2C;
                Size     = 2'b10;
                WriteData = 32'h1111_2222;
            end
            push_idle();
            tick("init2");
        end
        rst_n    = 1'b0;
        exp_hold = 32'h0;
        push_idle();
        tick("abort_rst");
        check("abort_busy_off", 32'(Busy), 32'd0);
        rst_n = 1'b1;
        for (int w = 0; w < 5; w++) begin
            mdl[4*w] = 8'h00; mdl[4*w+1] = 8'h00; mdl[4*w+2] = 8'h00; mdl[4*w+3] = 8'h01;
        end
        for (int w = 0; w < 6; w++) issue("post_abort", 1, 0, 32'(4*w), 32'h0, 2'b10, 0);
        check("word5_const", last_rd, 32'hA5A5_0005);
        issue("rd_2c", 1, 0, 32'h2C, 32'h0, 2'b10, 0);
        push_idle();
        tick("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
- Parametrised, byte-addressed, big-endian data memory for the single-cycle/pipelined CPU datapath.
- Successor to the fixed 44-byte word-only memory: configurable depth, and byte/half/word accesses with sign/zero extension.
- Registered (1-cycle) read, misalignment/range error flag, and a multi-cycle init sequencer driven by Startin.
- Sits between the ALU address output and the writeback mux.

Parameters:
- DEPTH_BYTES, 64, memory size in bytes; must be a multiple of 4 and at least 4.
- INIT_WORD, 32'h0000_0001, value written to every aligned word during init.
- INIT_WORDS, DEPTH_BYTES/4, number of words filled by init, starting at byte 0; must be at most DEPTH_BYTES/4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- Startin  input  1  start init sequence; level-sampled, acted on only in IDLE.
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- Address  input  32  byte address.
- WriteData  input  32  store data; right-justified for byte/half.
- Size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
- ReadData  output  32  registered load result.
- ReadValid  output  1  1-cycle pulse; ReadData is valid.
- Busy  output  1  init in progress; requests are ignored.
- Error  output  1  1-cycle pulse on an illegal access.

Behaviour:
- Reset (rst_n=0 at a clock edge): state goes to IDLE, init counter 0; ReadData=0, ReadValid=0, Busy=0, Error=0. Array contents are not cleared.
- Reset during INIT aborts the sequence. Words already written keep INIT_WORD; the rest are unchanged.
- FSM has two states, IDLE and INIT.
  - IDLE with Startin=1: go to INIT, counter=0, Busy=1 from the next cycle.
  - INIT: write INIT_WORD at word counter (byte address 4*counter), one word per cycle, big-endian, then increment the counter.
  - After word INIT_WORDS-1: return to IDLE; Busy deasserts the following cycle.
  - Startin during INIT is ignored (no restart).
- Requests are accepted only in IDLE with Busy=0. MemRead/MemWrite while Busy are dropped: no ReadValid, no Error, no write.
- Legality check, applied to every accepted request:
  - Size=11 is illegal.
  - Half with Address[0]=1 is illegal.
  - Word with Address[1:0]!=0 is illegal.
  - Address+bytes>DEPTH_BYTES is illegal; the compare is done in 33-bit arithmetic, so there is no wrap.
  - Illegal access: no write. A read returns ReadData=0 with ReadValid=1. Error=1 for one cycle in both cases.
- Write, legal: on the accept edge, store big-endian. Byte: mem[A]=WD[7:0]. Half: mem[A]=WD[15:8], mem[A+1]=WD[7:0]. Word: mem[A..A+3]=WD[31:24..7:0].
- Read, legal: latency 1.
  - ReadData and ReadValid update on the edge following sampling; ReadValid=1 for exactly one cycle per accepted read.
  - Byte: {24{ext}, mem[A]}. Half: {16{ext}, mem[A], mem[A+1]}. ext = Unsigned ? 0 : MSB of the loaded value.
  - Back-to-back reads: one result per cycle.
- ReadData holds its last value when ReadValid=0.
- MemRead and MemWrite in the same cycle: both are performed. Overlapping bytes follow the forwarding rule (see Optional Feature).

Optional Feature:
- Macro: DMEM_WRITE_FORWARD_EN.
- Defined: a same-cycle read returns the post-write bytes for every overlapping byte lane (write-first).
- Undefined: the read returns the pre-write contents (read-first).
- Both modes are otherwise identical.

Test Plan:
- Reset, then Startin=1 for 1 cycle (DEPTH_BYTES=64) -> Busy=1 for exactly 16 cycles. Word read at 0x3C returns 0x00000001, ReadValid one cycle after the request.
- Word write 0xDEADBEEF at 0x8, then byte read 0x8 with Unsigned=0 -> 0xFFFFFFDE. Byte read 0xB with Unsigned=1 -> 0x000000EF. Half read 0xA with Unsigned=0 -> 0xFFFFBEEF.
- Half write 0x1234 at 0x11 -> Error pulse, no write; a subsequent word read at 0x10 is unchanged. Word read at 0x3E -> Error=1, ReadData=0, ReadValid=1.
- Word read at 0x3C -> legal. Byte read at 0x40 -> out of range: Error=1, ReadValid=1, ReadData=0.
- Word write 0xCAFEF00D and word read at 0x20 in the same cycle, with old value 0x1 -> ReadData=0x00000001 without DMEM_WRITE_FORWARD_EN, 0xCAFEF00D with it.
- rst_n=0 at cycle 5 of init -> Busy=0 next cycle. Words 0 to 4 hold 0x1; word 5 keeps its prior written value. MemRead issued during Busy produces no ReadValid.
